// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
// TOUR_FANFARE_EN selects the opcode used for the horizontal leg.
package tour_pkg;

    localparam int          NUM_MOVES = 24;
    localparam logic [7:0]  RESP_ACK  = 8'hA5;
    localparam logic [7:0]  RESP_DONE = 8'h5A;

    localparam logic [3:0]  OP_MOVE    = 4'h2;
    localparam logic [3:0]  OP_FANFARE = 4'h3;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0]  OP_HORZ    = OP_FANFARE;
`else
    localparam logic [3:0]  OP_HORZ    = OP_MOVE;
`endif

    // Upper byte of the 12-bit heading field.
    localparam logic [7:0]  HDG_N = 8'h00;
    localparam logic [7:0]  HDG_S = 8'h7F;
    localparam logic [7:0]  HDG_E = 8'hBF;
    localparam logic [7:0]  HDG_W = 8'h3F;

    localparam logic [7:0]  MV_B0 = 8'h01;  // (-1,+2)
    localparam logic [7:0]  MV_B1 = 8'h02;  // (+1,+2)
    localparam logic [7:0]  MV_B2 = 8'h04;  // (-2,+1)
    localparam logic [7:0]  MV_B3 = 8'h08;  // (-2,-1)
    localparam logic [7:0]  MV_B4 = 8'h10;  // (-1,-2)
    localparam logic [7:0]  MV_B5 = 8'h20;  // (+1,-2)
    localparam logic [7:0]  MV_B6 = 8'h40;  // (+2,-1)
    localparam logic [7:0]  MV_B7 = 8'h80;  // (+2,+1)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VERT   = 3'd1,
        ST_HOLD_V = 3'd2,
        ST_HORZ   = 3'd3,
        ST_HOLD_H = 3'd4
    } tour_state_t;

    function automatic logic [15:0] build_cmd(input logic [3:0] op,
                                              input logic [7:0] hdg,
                                              input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational decode of a one-hot knight move into vertical and horizontal legs.
// Anything that is not exactly one-hot decodes to a zero-length northward leg.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move_i,
    output logic [7:0] hdg_v_o,
    output logic [3:0] sq_v_o,
    output logic [7:0] hdg_h_o,
    output logic [3:0] sq_h_o
);

    always_comb begin
        hdg_v_o = HDG_N;
        sq_v_o  = 4'd0;
        hdg_h_o = HDG_N;
        sq_h_o  = 4'd0;
        unique case (move_i)
            MV_B0: begin hdg_v_o = HDG_N; sq_v_o = 4'd2; hdg_h_o = HDG_W; sq_h_o = 4'd1; end
            MV_B1: begin hdg_v_o = HDG_N; sq_v_o = 4'd2; hdg_h_o = HDG_E; sq_h_o = 4'd1; end
            MV_B2: begin hdg_v_o = HDG_N; sq_v_o = 4'd1; hdg_h_o = HDG_W; sq_h_o = 4'd2; end
            MV_B3: begin hdg_v_o = HDG_S; sq_v_o = 4'd1; hdg_h_o = HDG_W; sq_h_o = 4'd2; end
            MV_B4: begin hdg_v_o = HDG_S; sq_v_o = 4'd2; hdg_h_o = HDG_W; sq_h_o = 4'd1; end
            MV_B5: begin hdg_v_o = HDG_S; sq_v_o = 4'd2; hdg_h_o = HDG_E; sq_h_o = 4'd1; end
            MV_B6: begin hdg_v_o = HDG_S; sq_v_o = 4'd1; hdg_h_o = HDG_E; sq_h_o = 4'd2; end
            MV_B7: begin hdg_v_o = HDG_N; sq_v_o = 4'd1; hdg_h_o = HDG_E; sq_h_o = 4'd2; end
            default: begin
                hdg_v_o = HDG_N;
                sq_v_o  = 4'd0;
                hdg_h_o = HDG_N;
                sq_h_o  = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays the solver's move list as vertical/horizontal command pairs, overriding the UART path.
// TOUR_FANFARE_EN (in tour_pkg) makes the horizontal leg a fanfare command.
module tour_cmd_seq
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output tour_state_t state_dbg
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    // Handshake: a leg is offered with cmd_rdy=1 and is accepted on clr_cmd_rdy;
    // the leg is complete on send_resp, which is only honoured after acceptance.

    tour_state_t state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;

    logic [7:0]  hdg_v, hdg_h;
    logic [3:0]  sq_v, sq_h;
    logic [15:0] tour_cmd;
    logic        tour_cmd_rdy;
    logic        tour_active;

    tour_move_decode u_decode (
        .move_i  (move),
        .hdg_v_o (hdg_v),
        .sq_v_o  (sq_v),
        .hdg_h_o (hdg_h),
        .sq_h_o  (sq_h)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_tour) begin
                    state_d   = ST_VERT;
                    mv_indx_d = 5'd0;
                end
            end
            ST_VERT: begin
                if (clr_cmd_rdy) state_d = ST_HOLD_V;
            end
            ST_HOLD_V: begin
                if (send_resp) state_d = ST_HORZ;
            end
            ST_HORZ: begin
                if (clr_cmd_rdy) state_d = ST_HOLD_H;
            end
            ST_HOLD_H: begin
                if (send_resp) begin
                    if (mv_indx_q == LAST_INDX) begin
                        state_d   = ST_IDLE;
                        mv_indx_d = 5'd0;
                    end else begin
                        state_d   = ST_VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mv_indx_d = 5'd0;
            end
        endcase
    end

    always_comb begin
        tour_cmd     = 16'h0000;
        tour_cmd_rdy = 1'b0;
        resp         = RESP_ACK;
        unique case (state_q)
            ST_VERT: begin
                tour_cmd     = build_cmd(OP_MOVE, hdg_v, sq_v);
                tour_cmd_rdy = 1'b1;
            end
            ST_HORZ: begin
                tour_cmd     = build_cmd(OP_HORZ, hdg_h, sq_h);
                tour_cmd_rdy = 1'b1;
            end
            ST_HOLD_H: begin
                if (mv_indx_q == LAST_INDX) resp = RESP_DONE;
            end
            default: begin
                tour_cmd     = 16'h0000;
                tour_cmd_rdy = 1'b0;
            end
        endcase
    end

    // UART requests arriving mid-tour are dropped, not deferred.
    assign tour_active = (state_q != ST_IDLE);
    assign cmd         = tour_active ? tour_cmd     : cmd_UART;
    assign cmd_rdy     = tour_active ? tour_cmd_rdy : cmd_rdy_UART;
    assign mv_indx     = mv_indx_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: reset, leg encoding, full replay, UART mux, boundaries.
module tb_tour_cmd_seq;
  import tour_pkg::*;

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] EXP_OPH = 4'h3;
`else
  localparam logic [3:0] EXP_OPH = 4'h2;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  tour_state_t state_dbg;

  logic [7:0]  move_mem [24];
  int          checks = 0;
  int          passed = 0;
  int          rise_cnt = 0;
  logic        rdy_prev = 1'b0;

  // Hand-derived legs for each single-bit move, bit index 0..7.
  logic [15:0] exp_v [8];
  logic [11:0] exp_h_low [8];

  tour_cmd_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // solver read port model
  always_comb begin
    move = 8'h00;
    if (mv_indx < 5'd24) move = move_mem[mv_indx];
  end

  // count cmd_rdy rising edges, sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_rdy && !rdy_prev) rise_cnt <= rise_cnt + 1;
    rdy_prev <= cmd_rdy;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_UART = 16'hBEEF;
    cmd_rdy_UART = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE); else passed++;
    checks++; if (mv_indx !== 5'd0) $display("FAIL reset_indx got %0d exp 0", mv_indx); else passed++;
    checks++; if (resp !== 8'hA5) $display("FAIL reset_resp got %h exp a5", resp); else passed++;
    checks++; if (cmd !== 16'hBEEF) $display("FAIL reset_cmd got %h exp beef", cmd); else passed++;
    checks++; if (cmd_rdy !== 1'b0) $display("FAIL reset_cmd_rdy got %b exp 0", cmd_rdy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_move_01();
    move_mem[0] = 8'h01;
    pulse_start();
    checks++; if (state_dbg !== ST_VERT) $display("FAIL m01_vert_state got %0d exp %0d", state_dbg, ST_VERT); else passed++;
    checks++; if (cmd_rdy !== 1'b1) $display("FAIL m01_vert_rdy got %b exp 1", cmd_rdy); else passed++;
    checks++; if (cmd !== 16'h2002) $display("FAIL m01_vert_cmd got %h exp 2002", cmd); else passed++;
    pulse_clr();
    pulse_send();
    checks++; if (cmd !== {EXP_OPH, 12'h3F1}) $display("FAIL m01_horz_cmd got %h exp %h", cmd, {EXP_OPH, 12'h3F1}); else passed++;
    apply_reset();
  endtask

  task automatic test_move_40();
    move_mem[0] = 8'h40;
    pulse_start();
    checks++; if (cmd !== 16'h27F1) $display("FAIL m40_vert_cmd got %h exp 27f1", cmd); else passed++;
    pulse_clr();
    pulse_send();
    checks++; if (cmd !== {EXP_OPH, 12'hBF2}) $display("FAIL m40_horz_cmd got %h exp %h", cmd, {EXP_OPH, 12'hBF2}); else passed++;
    pulse_clr();
    checks++; if (state_dbg !== ST_HOLD_H) $display("FAIL m40_hold_h got %0d exp %0d", state_dbg, ST_HOLD_H); else passed++;
    checks++; if (resp !== 8'hA5) $display("FAIL m40_resp got %h exp a5", resp); else passed++;
    pulse_send();
    checks++; if (mv_indx !== 5'd1) $display("FAIL m40_next_indx got %0d exp 1", mv_indx); else passed++;
    apply_reset();
  endtask

  task automatic test_non_onehot();
    move_mem[0] = 8'h03;
    move_mem[1] = 8'h00;
    pulse_start();
    checks++; if (cmd !== 16'h2000) $display("FAIL nh03_vert_cmd got %h exp 2000", cmd); else passed++;
    pulse_clr();
    pulse_send();
    checks++; if (cmd !== {EXP_OPH, 12'h000}) $display("FAIL nh03_horz_cmd got %h exp %h", cmd, {EXP_OPH, 12'h000}); else passed++;
    pulse_clr();
    pulse_send();
    checks++; if (cmd !== 16'h2000 || mv_indx !== 5'd1) $display("FAIL nh00_vert got cmd %h indx %0d exp 2000 1", cmd, mv_indx); else passed++;
    apply_reset();
  endtask

  task automatic test_full_replay();
    for (int i = 0; i < 24; i++) move_mem[i] = 8'h01 << (i % 8);
    @(negedge clk);
    rise_cnt = 0;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      checks++; if (state_dbg !== ST_VERT || mv_indx !== 5'(i)) $display("FAIL replay_vert_idx got st %0d idx %0d exp st 1 idx %0d", state_dbg, mv_indx, i); else passed++;
      checks++; if (cmd !== exp_v[i % 8] || cmd_rdy !== 1'b1) $display("FAIL replay_vert_cmd idx %0d got %h/%b exp %h/1", i, cmd, cmd_rdy, exp_v[i % 8]); else passed++;
      pulse_clr();
      checks++; if (state_dbg !== ST_HOLD_V || cmd_rdy !== 1'b0) $display("FAIL replay_hold_v idx %0d got st %0d rdy %b exp st 2 rdy 0", i, state_dbg, cmd_rdy); else passed++;
      pulse_send();
      checks++; if (cmd !== {EXP_OPH, exp_h_low[i % 8]} || cmd_rdy !== 1'b1) $display("FAIL replay_horz_cmd idx %0d got %h/%b exp %h/1", i, cmd, cmd_rdy, {EXP_OPH, exp_h_low[i % 8]}); else passed++;
      pulse_clr();
      checks++; if (resp !== ((i == 23) ? 8'h5A : 8'hA5)) $display("FAIL replay_resp idx %0d got %h exp %h", i, resp, (i == 23) ? 8'h5A : 8'hA5); else passed++;
      pulse_send();
    end
    checks++; if (state_dbg !== ST_IDLE || mv_indx !== 5'd0) $display("FAIL replay_end got st %0d idx %0d exp st 0 idx 0", state_dbg, mv_indx); else passed++;
    checks++; if (resp !== 8'hA5) $display("FAIL replay_end_resp got %h exp a5", resp); else passed++;
    @(negedge clk);
    checks++; if (rise_cnt !== 48) $display("FAIL replay_rdy_count got %0d exp 48", rise_cnt); else passed++;
  endtask

  task automatic test_uart_mux();
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #1;
    checks++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) $display("FAIL uart_idle got %h/%b exp 1234/1", cmd, cmd_rdy); else passed++;
    move_mem[0] = 8'h80;
    pulse_start();
    checks++; if (cmd !== 16'h2001 || cmd_rdy !== 1'b1) $display("FAIL uart_mask_vert got %h/%b exp 2001/1", cmd, cmd_rdy); else passed++;
    pulse_clr();
    checks++; if (cmd_rdy !== 1'b0) $display("FAIL uart_mask_hold got %b exp 0", cmd_rdy); else passed++;
    apply_reset();
    cmd_rdy_UART = 1'b0;
    #1;
  endtask

  task automatic test_boundaries();
    move_mem[0] = 8'h02;
    move_mem[1] = 8'h04;
    pulse_start();
    pulse_send();
    checks++; if (state_dbg !== ST_VERT || mv_indx !== 5'd0) $display("FAIL send_in_vert got st %0d idx %0d exp st 1 idx 0", state_dbg, mv_indx); else passed++;
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    checks++; if (state_dbg !== ST_HOLD_V) $display("FAIL clr_send_same got st %0d exp 2", state_dbg); else passed++;
    pulse_start();
    checks++; if (state_dbg !== ST_HOLD_V || mv_indx !== 5'd0) $display("FAIL start_in_hold_v got st %0d idx %0d exp st 2 idx 0", state_dbg, mv_indx); else passed++;
    pulse_clr();
    checks++; if (state_dbg !== ST_HOLD_V) $display("FAIL clr_in_hold_v got st %0d exp 2", state_dbg); else passed++;
    pulse_send();
    pulse_send();
    checks++; if (state_dbg !== ST_HORZ) $display("FAIL send_in_horz got st %0d exp 3", state_dbg); else passed++;
    pulse_clr();
    pulse_clr();
    checks++; if (state_dbg !== ST_HOLD_H) $display("FAIL clr_in_hold_h got st %0d exp 4", state_dbg); else passed++;
    pulse_send();
    checks++; if (mv_indx !== 5'd1 || cmd !== 16'h2001) $display("FAIL boundary_next got idx %0d cmd %h exp 1 2001", mv_indx, cmd); else passed++;
    apply_reset();
  endtask

  task automatic test_reset_mid_tour();
    for (int i = 0; i < 24; i++) move_mem[i] = 8'h20;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      pulse_clr();
      pulse_send();
      pulse_clr();
      pulse_send();
    end
    pulse_clr();
    pulse_send();
    pulse_clr();
    checks++; if (state_dbg !== ST_HOLD_H || mv_indx !== 5'd7) $display("FAIL pre_reset got st %0d idx %0d exp st 4 idx 7", state_dbg, mv_indx); else passed++;
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_IDLE || mv_indx !== 5'd0) $display("FAIL async_reset got st %0d idx %0d exp st 0 idx 0", state_dbg, mv_indx); else passed++;
    checks++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) $display("FAIL async_reset_mux got %h/%b exp 1234/1", cmd, cmd_rdy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    exp_v[0] = 16'h2002; exp_h_low[0] = 12'h3F1;
    exp_v[1] = 16'h2002; exp_h_low[1] = 12'hBF1;
    exp_v[2] = 16'h2001; exp_h_low[2] = 12'h3F2;
    exp_v[3] = 16'h27F1; exp_h_low[3] = 12'h3F2;
    exp_v[4] = 16'h27F2; exp_h_low[4] = 12'h3F1;
    exp_v[5] = 16'h27F2; exp_h_low[5] = 12'hBF1;
    exp_v[6] = 16'h27F1; exp_h_low[6] = 12'hBF2;
    exp_v[7] = 16'h2001; exp_h_low[7] = 12'hBF2;
    for (int i = 0; i < 24; i++) move_mem[i] = 8'h00;
    start_tour = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;

    test_reset();
    test_move_01();
    test_move_40();
    test_non_onehot();
    test_full_replay();
    test_uart_mux();
    test_boundaries();
    test_reset_mid_tour();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
